// File: rtl/stopwatch_mmss_if.sv
// Stopwatch control pulses and count/display outputs, bundled so that the
// debounce/tick side and the display side can share one port.
interface stopwatch_mmss_if;
    logic        tick;
    logic        start_stop;
    logic        clear;
    logic [15:0] bcd;
    logic        running;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output tick, start_stop, clear,
        input  bcd, running, wrap, an, seg, dp
    );

    modport slave (
        input  tick, start_stop, clear,
        output bcd, running, wrap, an, seg, dp
    );
endinterface

// File: rtl/stopwatch_mmss.sv
// MM:SS BCD stopwatch advanced by a 1 Hz clock-enable tick, with a
// registered multiplexed driver for a 4-digit active-low seven-segment display.
module stopwatch_mmss #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic             clk_in,
    input  logic             reset,
    stopwatch_mmss_if.slave  sw
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   bcd_q, bcd_d, bcd_inc;
    logic          wrap_q, wrap_d, full_wrap;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    digit;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Ripple-carry BCD increment; a digit at or above its limit rolls to 0.
    always_comb begin
        bcd_inc   = bcd_q;
        full_wrap = 1'b0;
        if (bcd_q[3:0] < 4'd9) begin
            bcd_inc[3:0] = bcd_q[3:0] + 4'd1;
        end else begin
            bcd_inc[3:0] = '0;
            if (bcd_q[7:4] < 4'd5) begin
                bcd_inc[7:4] = bcd_q[7:4] + 4'd1;
            end else begin
                bcd_inc[7:4] = '0;
                if (bcd_q[11:8] < 4'd9) begin
                    bcd_inc[11:8] = bcd_q[11:8] + 4'd1;
                end else begin
                    bcd_inc[11:8] = '0;
                    if (bcd_q[15:12] < 4'd5) begin
                        bcd_inc[15:12] = bcd_q[15:12] + 4'd1;
                    end else begin
                        bcd_inc[15:12] = '0;
                        full_wrap      = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        wrap_d  = 1'b0;
        if (sw.clear) begin
            state_d = STOPPED;
            bcd_d   = '0;
        end else begin
            if (state_q == RUNNING && sw.tick) begin
                bcd_d  = bcd_inc;
                wrap_d = full_wrap;
            end
            if (sw.start_stop) begin
                state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
        case (idx_q)
            2'd0:    digit = bcd_q[3:0];
            2'd1:    digit = bcd_q[7:4];
            2'd2:    digit = bcd_q[11:8];
            default: digit = bcd_q[15:12];
        endcase
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg7(digit);
        dp_d  = (idx_q != 2'd2);
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= STOPPED;
            bcd_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign sw.bcd     = bcd_q;
    assign sw.running = (state_q == RUNNING);
    assign sw.wrap    = wrap_q;
    assign sw.an      = an_q;
    assign sw.seg     = seg_q;
    assign sw.dp      = dp_q;

endmodule

// File: tb/tb_stopwatch_mmss.sv
// Bench for stopwatch_mmss: elapsed seconds and scan phase are modelled as
// plain integers and every output is compared against them on every cycle.
module tb_stopwatch_mmss;

    localparam int unsigned SCAN_DIV = 4;

    logic clk_in = 1'b0;
    logic reset  = 1'b1;

    stopwatch_mmss_if sw_if ();

    stopwatch_mmss #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .sw     (sw_if)
    );

    always #5 clk_in = ~clk_in;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference state: elapsed seconds, run flag, and cycles into the scan.
    int          m_secs;
    bit          m_run;
    bit          m_wrap;
    int          m_scan;
    logic [3:0]  m_an;
    logic [6:0]  m_seg;
    logic        m_dp;
    logic [6:0]  seg_tab [10];

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return 16'((mm / 10) * 4096 + (mm % 10) * 256 + (ss / 10) * 16 + (ss % 10));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit t, input bit ss, input bit clr);
        int digit_pos;
        logic [15:0] cur;
        if (rst) begin
            m_secs = 0; m_run = 0; m_wrap = 0; m_scan = 0;
            m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
            return;
        end
        digit_pos = (m_scan / SCAN_DIV) % 4;
        cur       = to_bcd(m_secs);
        m_an      = ~(4'(1) << digit_pos);
        m_seg     = seg_tab[(cur >> (4 * digit_pos)) & 16'hF];
        m_dp      = (digit_pos == 2) ? 1'b0 : 1'b1;
        m_scan    = (m_scan + 1) % (4 * SCAN_DIV);
        m_wrap    = 0;
        if (clr) begin
            m_secs = 0;
            m_run  = 0;
        end else begin
            if (m_run && t) begin
                m_secs = m_secs + 1;
                if (m_secs == 3600) begin
                    m_secs = 0;
                    m_wrap = 1;
                end
            end
            if (ss) m_run = !m_run;
        end
    endtask

    task automatic cycle(input bit rst, input bit t, input bit ss, input bit clr);
        reset            = rst;
        sw_if.tick       = t;
        sw_if.start_stop = ss;
        sw_if.clear      = clr;
        @(posedge clk_in);
        model_edge(rst, t, ss, clr);
        #1;
        check("bcd",     32'(sw_if.bcd),     32'(to_bcd(m_secs)));
        check("running", 32'(sw_if.running), 32'(m_run));
        check("wrap",    32'(sw_if.wrap),    32'(m_wrap));
        check("an",      32'(sw_if.an),      32'(m_an));
        check("seg",     32'(sw_if.seg),     32'(m_seg));
        check("dp",      32'(sw_if.dp),      32'(m_dp));
        reset            = 1'b0;
        sw_if.tick       = 1'b0;
        sw_if.start_stop = 1'b0;
        sw_if.clear      = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 0);
    endtask

    initial begin
        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        sw_if.tick = 1'b0; sw_if.start_stop = 1'b0; sw_if.clear = 1'b0;
        m_secs = 0; m_run = 0; m_wrap = 0; m_scan = 0;
        m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;

        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("rst_an",  32'(sw_if.an),  32'h0000000F);
        check("rst_seg", 32'(sw_if.seg), 32'h0000007F);
        check("rst_dp",  32'(sw_if.dp),  32'h00000001);
        cycle(0, 0, 0, 0);
        check("first_an", 32'(sw_if.an), 32'h0000000E);

        ticks(3);
        check("s1_bcd", 32'(sw_if.bcd), 32'h0000);
        check("s1_run", 32'(sw_if.running), 32'h0);

        cycle(0, 0, 1, 0);
        ticks(75);
        check("s2_bcd", 32'(sw_if.bcd), 32'h0115);
        check("s2_run", 32'(sw_if.running), 32'h1);
        cycle(0, 0, 1, 0);
        ticks(5);
        check("s2_bcd_stop", 32'(sw_if.bcd), 32'h0115);
        check("s2_run_stop", 32'(sw_if.running), 32'h0);

        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        ticks(3599);
        check("s3_bcd_max", 32'(sw_if.bcd), 32'h5959);
        check("s3_wrap_pre", 32'(sw_if.wrap), 32'h0);
        ticks(1);
        check("s3_bcd_wrap", 32'(sw_if.bcd), 32'h0000);
        check("s3_wrap", 32'(sw_if.wrap), 32'h1);
        check("s3_run", 32'(sw_if.running), 32'h1);
        cycle(0, 0, 0, 0);
        check("s3_wrap_once", 32'(sw_if.wrap), 32'h0);

        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        ticks(42);
        check("s4_bcd_pre", 32'(sw_if.bcd), 32'h0042);
        cycle(0, 1, 0, 1);
        check("s4_bcd_clr", 32'(sw_if.bcd), 32'h0000);
        check("s4_run_clr", 32'(sw_if.running), 32'h0);
        ticks(1);
        check("s4_bcd_idle", 32'(sw_if.bcd), 32'h0000);

        cycle(0, 0, 1, 0);
        ticks(9);
        check("s5_bcd_pre", 32'(sw_if.bcd), 32'h0009);
        cycle(0, 1, 1, 0);
        check("s5_bcd_stop", 32'(sw_if.bcd), 32'h0010);
        check("s5_run_stop", 32'(sw_if.running), 32'h0);
        ticks(1);
        check("s5_bcd_hold", 32'(sw_if.bcd), 32'h0010);
        cycle(0, 1, 1, 0);
        check("s5_bcd_start", 32'(sw_if.bcd), 32'h0010);
        check("s5_run_start", 32'(sw_if.running), 32'h1);

        cycle(0, 0, 0, 1);
        cycle(0, 0, 1, 0);
        ticks(754);
        cycle(0, 0, 1, 0);
        check("s6_bcd", 32'(sw_if.bcd), 32'h1234);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("s6_rst_an",  32'(sw_if.an),  32'h0000000F);
        check("s6_rst_seg", 32'(sw_if.seg), 32'h0000007F);

        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 255) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
